// File: rtl/subtractor_pkg.sv
// Shared constants for the registered 4-bit subtractor.
// Optional SUB_OVF_EN adds the signed overflow output.
package subtractor_pkg;

  localparam int SUB_WIDTH = 4;

  localparam logic [SUB_WIDTH-1:0] DIFF_RST = 4'h0;
  localparam logic                 COUT_RST = 1'b0;

endpackage

// File: rtl/subtractor_4bit_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin.
// Chained through bin/bout to form the ripple borrow path.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/subtractor_4bit.sv
// Registered 4-bit unsigned subtractor with ripple borrow chain.
// Define SUB_OVF_EN to add the registered signed overflow flag.
module subtractor_4bit
  import subtractor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [SUB_WIDTH-1:0] a,
  input  logic [SUB_WIDTH-1:0] b,
  output logic [SUB_WIDTH-1:0] diff,
  output logic                 cout,
`ifdef SUB_OVF_EN
  output logic                 ovf,
`endif
  output logic                 out_valid
);

  logic [SUB_WIDTH:0]   borrow;
  logic [SUB_WIDTH-1:0] diff_next;
  logic                 cout_next;

  assign borrow[0] = 1'b0;

  for (genvar i = 0; i < SUB_WIDTH; i++) begin : g_cell
    full_subtractor u_fs (
      .x    (a[i]),
      .y    (b[i]),
      .bin  (borrow[i]),
      .d    (diff_next[i]),
      .bout (borrow[i+1])
    );
  end

  // No borrow out of the MSB means a >= b.
  assign cout_next = ~borrow[SUB_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      diff      <= DIFF_RST;
      cout      <= COUT_RST;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff <= diff_next;
        cout <= cout_next;
      end
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_next;

  assign ovf_next = (a[SUB_WIDTH-1] != b[SUB_WIDTH-1]) &&
                    (diff_next[SUB_WIDTH-1] != a[SUB_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= ovf_next;
    end
  end
`endif

endmodule

// File: tb/tb_subtractor_4bit.sv
// Scoreboard bench for subtractor_4bit.
// Build with SUB_OVF_EN to also check the overflow flag.
module tb_subtractor_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] diff;
  logic       cout;
  logic       out_valid;
`ifdef SUB_OVF_EN
  logic       ovf;
`endif

  subtractor_4bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .diff      (diff),
    .cout      (cout),
`ifdef SUB_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       vld;
    logic [3:0] d;
    logic       c;
    logic       o;
  } exp_t;

  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  logic [3:0] m_d = 4'h0;
  logic       m_c = 1'b0;
  logic       m_o = 1'b0;

  task automatic check(input string tag, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  // Apply inputs across one rising edge, then record what must appear.
  task automatic drive(input string tag, input logic r, input logic v,
                       input int ia, input int ib);
    exp_t e;
    int   dd;
    rst      = r;
    in_valid = v;
    a        = 4'(ia);
    b        = 4'(ib);
    @(posedge clk);
    if (r) begin
      m_d = 4'h0;
      m_c = 1'b0;
      m_o = 1'b0;
    end else if (v) begin
      dd  = (ia - ib + 16) % 16;
      m_d = 4'(dd);
      m_c = (ia >= ib);
      m_o = (ia >= 8) != (ib >= 8) && (dd >= 8) != (ia >= 8);
    end
    e.tag = tag;
    e.vld = !r && v;
    e.d   = m_d;
    e.c   = m_c;
    e.o   = m_o;
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".valid"}, int'(out_valid), int'(e.vld));
      check({e.tag, ".diff"}, int'(diff), int'(e.d));
      check({e.tag, ".cout"}, int'(cout), int'(e.c));
`ifdef SUB_OVF_EN
      check({e.tag, ".ovf"}, int'(ovf), int'(e.o));
`endif
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'h0;
    b        = 4'h0;
    drive("reset", 1, 0, 0, 0);
    drive("rst_drop", 1, 1, 9, 3);
    drive("hold0", 0, 0, 9, 3);
    drive("9-3", 0, 1, 9, 3);
    drive("7-9", 0, 1, 7, 9);
    drive("5-5", 0, 1, 5, 5);
    drive("12-6", 0, 1, 12, 6);
    drive("hold1", 0, 0, 1, 2);
    drive("hold2", 0, 0, 3, 4);
    drive("8-1", 0, 1, 8, 1);
    drive("7-15", 0, 1, 7, 15);
    drive("0-15", 0, 1, 0, 15);
    drive("15-0", 0, 1, 15, 0);
    drive("0-0", 0, 1, 0, 0);
    drive("mid_rst", 1, 1, 14, 2);
    drive("post_rst", 0, 0, 14, 2);
    for (int i = 0; i < 256; i++) begin
      drive("sweep", 0, 1, i / 16, i % 16);
    end
    for (int i = 0; i < 40; i++) begin
      drive("rand", 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    drive("tail", 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
